// File: rtl/alu_md.sv
// alu_md: combinational ALU alongside an iterative shift-add multiplier / restoring divider.
// Define ALU_MD_SIGNED_EN to enable signed multiply/divide selected by md_op[1].
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  output logic             busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic             is_div;
  logic [WIDTH-1:0] rem, quo, opnd;
  logic [WIDTH-1:0] step_rem, step_quo, fix_hi, fix_lo, mag_a, mag_b, diff;
  logic [WIDTH:0]   sum, shifted;
  logic             fits;

  always_comb begin
    y = '0;
    case (op)
      4'b0000: y = a & b;
      4'b0001: y = a | b;
      4'b0010: y = a + b;
      4'b0110: y = a - b;
      4'b0111: y = {{(WIDTH-1){1'b0}}, a < b};
      4'b1000: y = b << a[SHW-1:0];
      4'b1010: y = b >> a[SHW-1:0];
      4'b0011: y = a ^ b;
      4'b0100: y = ~(a | b);
      4'b1011: y = $signed(b) >>> a[SHW-1:0];
      4'b1001: y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

`ifdef ALU_MD_SIGNED_EN
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] prod_neg;
  assign mag_a = (md_op[1] && a[WIDTH-1]) ? -a : a;
  assign mag_b = (md_op[1] && b[WIDTH-1]) ? -b : b;
`else
  logic md_op_unused;
  assign md_op_unused = md_op[1];
  assign mag_a = a;
  assign mag_b = b;
`endif

  // One iteration: multiply shifts {rem,quo} right after a conditional add,
  // divide shifts left and subtracts the divisor when the partial remainder fits.
  always_comb begin
    sum     = {1'b0, rem} + (quo[0] ? {1'b0, opnd} : '0);
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - opnd;
    fits    = (shifted >= {1'b0, opnd});
    if (is_div) begin
      step_rem = fits ? diff : shifted[WIDTH-1:0];
      step_quo = {quo[WIDTH-2:0], fits};
    end else begin
      step_rem = sum[WIDTH:1];
      step_quo = {sum[0], quo[WIDTH-1:1]};
    end
  end

  always_comb begin
    fix_hi = step_rem;
    fix_lo = step_quo;
`ifdef ALU_MD_SIGNED_EN
    prod_neg = -{step_rem, step_quo};
    if (is_div) begin
      if (neg_q) fix_lo = -step_quo;
      if (neg_r) fix_hi = -step_rem;
    end else if (neg_q) begin
      {fix_hi, fix_lo} = prod_neg;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      md_done <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      is_div  <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      opnd    <= '0;
`ifdef ALU_MD_SIGNED_EN
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          rem <= step_rem;
          quo <= step_quo;
          cnt <= cnt + 1'b1;
          if (cnt == SHW'(WIDTH - 1)) begin
            state   <= DONE;
            busy    <= 1'b0;
            md_done <= 1'b1;
            hi      <= fix_hi;
            lo      <= fix_lo;
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          md_done <= 1'b0;
          if (md_start) begin
            if (md_op[0] && b == '0) begin
              state   <= DONE;
              md_done <= 1'b1;
              hi      <= a;
              lo      <= '1;
            end else begin
              state  <= RUN;
              busy   <= 1'b1;
              cnt    <= '0;
              is_div <= md_op[0];
              rem    <= '0;
              quo    <= md_op[0] ? mag_a : mag_b;
              opnd   <= md_op[0] ? mag_b : mag_a;
`ifdef ALU_MD_SIGNED_EN
              neg_q  <= md_op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r  <= md_op[1] & a[WIDTH-1];
`endif
            end
          end
        end
      endcase
    end
  end
endmodule
